// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: FSM states, funct3
// width codes, and byte/half lane helpers used by load extraction.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Full funct3 codes (loads and stores share the low two bits)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in funct3[1:0]; funct3[2] marks zero-extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    // Byte lane off of a 32-bit word
    function automatic logic [LANE_W-1:0] lane_byte(input logic [31:0] w,
                                                    input logic [1:0]  off);
        return w[{off, 3'b000} +: LANE_W];
    endfunction

    // Half-word lane hi of a 32-bit word
    function automatic logic [15:0] lane_half(input logic [31:0] w,
                                              input logic        hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    // Encodings that no load/store may use, plus read+write together
    function automatic logic is_illegal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3);
        logic bad;
        bad = rd & wr;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
        if (wr && f3[2]) bad = 1'b1;   // no unsigned stores
        return bad;
    endfunction

    // Halves need even addresses, words need 4-byte alignment
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == SZ_H && off[0])         mis = 1'b1;
        if (f3[1:0] == SZ_W && off != 2'b00)   mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load extraction: picks the byte/half lane addressed by
// the low address bits and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [LANE_W-1:0] sel_b;
    logic [15:0]       sel_h;
    logic              sgn;

    // Lane select then extend; funct3[2] set means unsigned
    always_comb begin
        sel_b    = lane_byte(rdata, addr_lo);
        sel_h    = lane_half(rdata, addr_lo[1]);
        sgn      = ~funct3[2];
        ext_data = rdata;
        case (funct3[1:0])
            SZ_B:    ext_data = {{24{sgn & sel_b[7]}}, sel_b};
            SZ_H:    ext_data = {{16{sgn & sel_h[15]}}, sel_h};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs one req/ack transaction per load or
// store, stalls the front of the pipe meanwhile, and reports faults.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_cpu,
    input  logic        rst_cpu_n,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] rs2_data_mem,
    output logic        stall_mem,
    output logic [31:0] wd_data_mem,
    output logic        flag_mem,
    output logic        dram_req,
    output logic        dram_we,
    output logic [29:0] dram_addr,
    output logic [3:0]  dram_wstrb,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state;
    logic [CNT_W-1:0]  busy_cnt;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic              start;
    logic              fault;
    logic [3:0]        st_wstrb;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    assign start     = mem_valid & (mem_read | mem_write);
    assign fault     = is_illegal(mem_read, mem_write, funct3_mem) |
                       is_misaligned(funct3_mem, addr_mem[1:0]);
    assign stall_mem = ((state == ST_IDLE) & start) | (state == ST_BUSY);

    // Store lane formatting; loads drive no byte enables
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = rs2_data_mem;
        if (mem_write) begin
            case (funct3_mem[1:0])
                SZ_B: begin
                    st_wstrb = 4'b0001 << addr_mem[1:0];
                    st_wdata = {NUM_LANES{rs2_data_mem[7:0]}};
                end
                SZ_H: begin
                    st_wstrb = addr_mem[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{rs2_data_mem[15:0]}};
                end
                default: begin
                    st_wstrb = 4'b1111;
                    st_wdata = rs2_data_mem;
                end
            endcase
        end
    end

    // Extraction works on the latched width/offset so EX/MEM may change
    mem_load_align u_align (
        .rdata    (dram_rdata),
        .addr_lo  (off_q),
        .funct3   (f3_q),
        .ext_data (ld_data)
    );

    // Access FSM with registered request port, fault flag and load data
    always_ff @(posedge clk_cpu or negedge rst_cpu_n) begin
        if (!rst_cpu_n) begin
            state       <= ST_IDLE;
            busy_cnt    <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            dram_req    <= 1'b0;
            dram_we     <= 1'b0;
            dram_addr   <= '0;
            dram_wstrb  <= '0;
            dram_wdata  <= '0;
            wd_data_mem <= '0;
            flag_mem    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (fault) begin
                            // Faulting access never reaches the RAM
                            flag_mem <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            dram_req   <= 1'b1;
                            dram_we    <= mem_write;
                            dram_addr  <= addr_mem[31:2];
                            dram_wstrb <= st_wstrb;
                            dram_wdata <= st_wdata;
                            f3_q       <= funct3_mem;
                            off_q      <= addr_mem[1:0];
                            busy_cnt   <= '0;
                            state      <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dram_ack) begin
                        if (!dram_we) wd_data_mem <= ld_data;
                        dram_req <= 1'b0;
                        state    <= ST_DONE;
                    end else if (busy_cnt == CNT_LAST) begin
                        // No ack within budget: abort and poison the data
                        dram_req    <= 1'b0;
                        flag_mem    <= 1'b1;
                        wd_data_mem <= '0;
                        state       <= ST_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    flag_mem <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    dram_req <= 1'b0;
                    flag_mem <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, faults, timeout, reset.
module tb_mem_access;

    logic        clk_cpu;
    logic        rst_cpu_n;
    logic        mem_valid, mem_read, mem_write;
    logic [2:0]  funct3_mem;
    logic [31:0] addr_mem, rs2_data_mem;
    logic        stall_mem;
    logic [31:0] wd_data_mem;
    logic        flag_mem;
    logic        dram_req, dram_we;
    logic [29:0] dram_addr;
    logic [3:0]  dram_wstrb;
    logic [31:0] dram_wdata;
    logic        dram_ack;
    logic [31:0] dram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk_cpu      (clk_cpu),
        .rst_cpu_n    (rst_cpu_n),
        .mem_valid    (mem_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3_mem   (funct3_mem),
        .addr_mem     (addr_mem),
        .rs2_data_mem (rs2_data_mem),
        .stall_mem    (stall_mem),
        .wd_data_mem  (wd_data_mem),
        .flag_mem     (flag_mem),
        .dram_req     (dram_req),
        .dram_we      (dram_we),
        .dram_addr    (dram_addr),
        .dram_wstrb   (dram_wstrb),
        .dram_wdata   (dram_wdata),
        .dram_ack     (dram_ack),
        .dram_rdata   (dram_rdata)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results of one access, captured while it runs
    int          r_stalls, r_reqs;
    logic        r_we, r_flag, r_done;
    logic [29:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata, r_wd;

    // Present one instruction starting in IDLE (called at posedge+1).
    // ack_n: ack in the ack_n-th request cycle; 0 = never ack.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int ack_n, input logic [31:0] rdata);
        int busy_n;
        mem_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3_mem = f3; addr_mem = addr; rs2_data_mem = rs2;
        r_stalls = 0; r_reqs = 0; r_done = 1'b0; busy_n = 0;
        r_we = 1'bx; r_addr = 'x; r_wstrb = 'x; r_wdata = 'x;
        r_flag = 1'bx; r_wd = 'x;
        for (int c = 0; c < 40 && !r_done; c++) begin
            #1;
            if (dram_req) begin
                r_reqs++; busy_n++;
                r_we = dram_we; r_addr = dram_addr;
                r_wstrb = dram_wstrb; r_wdata = dram_wdata;
                if (ack_n != 0 && busy_n == ack_n) begin
                    dram_ack = 1'b1; dram_rdata = rdata;
                end
            end
            if (stall_mem) r_stalls++;
            else begin
                r_done = 1'b1; r_flag = flag_mem; r_wd = wd_data_mem;
                mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            end
            @(posedge clk_cpu); #1;
            dram_ack = 1'b0;
        end
        chk("access_completes", {31'd0, r_done}, 32'd1);
    endtask

    initial begin
        rst_cpu_n = 1'b0;
        mem_valid = 0; mem_read = 0; mem_write = 0;
        funct3_mem = 0; addr_mem = 0; rs2_data_mem = 0;
        dram_ack = 0; dram_rdata = 0;
        repeat (2) @(posedge clk_cpu);
        #1;
        chk("rst_req",   {31'd0, dram_req}, 32'd0);
        chk("rst_we",    {31'd0, dram_we},  32'd0);
        chk("rst_flag",  {31'd0, flag_mem}, 32'd0);
        chk("rst_addr",  {2'd0, dram_addr}, 32'd0);
        chk("rst_wstrb", {28'd0, dram_wstrb}, 32'd0);
        chk("rst_wdata", dram_wdata, 32'd0);
        chk("rst_wd",    wd_data_mem, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        rst_cpu_n = 1'b1;
        @(posedge clk_cpu); #1;

        // LW aligned, ack on first request cycle
        run(1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF);
        chk("lw_stalls", r_stalls, 2);
        chk("lw_reqs",   r_reqs, 1);
        chk("lw_we",     {31'd0, r_we}, 32'd0);
        chk("lw_addr",   {2'd0, r_addr}, 32'h40);
        chk("lw_wstrb",  {28'd0, r_wstrb}, 32'd0);
        chk("lw_flag",   {31'd0, r_flag}, 32'd0);
        chk("lw_wd",     r_wd, 32'hDEADBEEF);

        // Byte/half extraction, ack later for LB
        run(1, 0, 3'b000, 32'h103, 0, 2, 32'h80FF1234);
        chk("lb_stalls", r_stalls, 3);
        chk("lb_wd",  r_wd, 32'hFFFFFF80);
        run(1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF1234);
        chk("lbu_wd", r_wd, 32'h00000080);
        run(1, 0, 3'b001, 32'h102, 0, 1, 32'h80FF1234);
        chk("lh_wd",  r_wd, 32'hFFFF80FF);
        run(1, 0, 3'b101, 32'h102, 0, 1, 32'h80FF1234);
        chk("lhu_wd", r_wd, 32'h000080FF);
        run(1, 0, 3'b001, 32'h100, 0, 1, 32'h1234F00D);
        chk("lh_lo_wd", r_wd, 32'hFFFFF00D);

        // Stores: formatting, data register untouched
        run(0, 1, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0);
        chk("sb_wstrb", {28'd0, r_wstrb}, 32'b0010);
        chk("sb_wdata", r_wdata, 32'hA5A5A5A5);
        chk("sb_we",    {31'd0, r_we}, 32'd1);
        chk("sb_addr",  {2'd0, r_addr}, 32'h80);
        chk("sb_wd",    r_wd, 32'hFFFFF00D);
        chk("sb_flag",  {31'd0, r_flag}, 32'd0);
        run(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 1, 32'h0);
        chk("sh_wstrb", {28'd0, r_wstrb}, 32'b1100);
        chk("sh_wdata", r_wdata, 32'hBEEFBEEF);
        run(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 3, 32'h0);
        chk("sw_wstrb", {28'd0, r_wstrb}, 32'b1111);
        chk("sw_wdata", r_wdata, 32'hCAFEF00D);
        chk("sw_addr",  {2'd0, r_addr}, 32'h81);
        chk("sw_stalls", r_stalls, 4);

        // Misaligned LW: no request, one stall, flag, data held
        run(1, 0, 3'b010, 32'h102, 0, 1, 32'h11111111);
        chk("mis_lw_reqs",   r_reqs, 0);
        chk("mis_lw_stalls", r_stalls, 1);
        chk("mis_lw_flag",   {31'd0, r_flag}, 32'd1);
        chk("mis_lw_wd",     r_wd, 32'hFFFFF00D);
        chk("flag_clears",   {31'd0, flag_mem}, 32'd0);
        run(1, 0, 3'b001, 32'h101, 0, 1, 32'h11111111);
        chk("mis_lh_flag", {31'd0, r_flag}, 32'd1);
        chk("mis_lh_reqs", r_reqs, 0);

        // Illegal encodings
        run(0, 1, 3'b100, 32'h200, 32'h1, 1, 32'h0);
        chk("ill_sbu_flag", {31'd0, r_flag}, 32'd1);
        chk("ill_sbu_reqs", r_reqs, 0);
        run(1, 1, 3'b010, 32'h200, 32'h1, 1, 32'h0);
        chk("ill_rw_flag", {31'd0, r_flag}, 32'd1);
        run(1, 0, 3'b011, 32'h200, 0, 1, 32'h0);
        chk("ill_f3_flag", {31'd0, r_flag}, 32'd1);
        chk("ill_wd", r_wd, 32'hFFFFF00D);

        // Timeout: four request cycles, then fault with zeroed data
        run(1, 0, 3'b010, 32'h300, 0, 0, 32'h0);
        chk("to_reqs",   r_reqs, 4);
        chk("to_stalls", r_stalls, 5);
        chk("to_flag",   {31'd0, r_flag}, 32'd1);
        chk("to_wd",     r_wd, 32'd0);
        chk("to_req_low", {31'd0, dram_req}, 32'd0);

        run(1, 0, 3'b000, 32'h100, 0, 1, 32'h0000007F);
        chk("lb_pos_wd", r_wd, 32'h0000007F);

        // Ack outside BUSY is ignored
        dram_ack = 1'b1; dram_rdata = 32'h55555555;
        @(posedge clk_cpu); #1;
        dram_ack = 1'b0;
        chk("stray_ack_wd",  wd_data_mem, 32'h0000007F);
        chk("stray_ack_req", {31'd0, dram_req}, 32'd0);

        // Reset during the second BUSY cycle, late ack afterwards
        mem_valid = 1; mem_read = 1; mem_write = 0;
        funct3_mem = 3'b010; addr_mem = 32'h400;
        @(posedge clk_cpu); #1;
        chk("rb_req_b1", {31'd0, dram_req}, 32'd1);
        @(posedge clk_cpu); #2;
        rst_cpu_n = 1'b0;
        mem_valid = 0; mem_read = 0;
        #1;
        chk("rb_req_drop", {31'd0, dram_req}, 32'd0);
        chk("rb_stall",    {31'd0, stall_mem}, 32'd0);
        chk("rb_flag",     {31'd0, flag_mem}, 32'd0);
        @(posedge clk_cpu); #1;
        rst_cpu_n = 1'b1;
        @(posedge clk_cpu); #1;
        dram_ack = 1'b1; dram_rdata = 32'h12345678;
        @(posedge clk_cpu); #1;
        dram_ack = 1'b0;
        chk("rb_late_wd",    wd_data_mem, 32'd0);
        chk("rb_late_req",   {31'd0, dram_req}, 32'd0);
        chk("rb_late_stall", {31'd0, stall_mem}, 32'd0);
        chk("rb_late_flag",  {31'd0, flag_mem}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
